// File: rtl/router_rx_nsyn.sv
// Nibble-parallel serial receiver: deserializes one 128-bit frame (start, data symbols LSB-first, stop) into a bus-readable holding register.
// Latency: 2-flop input synchronizer; for 4 lanes x 4 clocks/symbol the frame lands in dat_o on the edge 136 cycles after rxd first goes low.
// Backpressure: cts (registered ~full) throttles the transmitter; a good frame that arrives while full is dropped and flagged as overrun.
module router_rx_nsyn #(
    parameter int pBitsParallel = 4,
    parameter int pClkMult      = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cs_i,
    input  logic                     cyc_i,
    input  logic                     stb_i,
    output logic                     ack_o,
    input  logic                     we_i,
    output logic [127:0]             dat_o,
    input  logic [pBitsParallel-1:0] rxd,
    output logic                     cts,
    output logic                     full,
    output logic                     frame_err,
    output logic                     overrun
);

    localparam int NSYM = 128 / pBitsParallel;
    localparam int CW   = (pClkMult > 1) ? $clog2(pClkMult) : 1;
    localparam int SW   = (NSYM > 1) ? $clog2(NSYM) : 1;

    localparam logic [CW-1:0] CTR_HALF = CW'(pClkMult / 2 - 1);
    localparam logic [CW-1:0] CTR_LAST = CW'(pClkMult - 1);
    localparam logic [SW-1:0] SC_LAST  = SW'(NSYM - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [pBitsParallel-1:0] sync1_q;
    logic [pBitsParallel-1:0] rxd_s_q;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] ctr_q, ctr_d;
    logic [SW-1:0] sc_q, sc_d;
    logic [127:0]  shreg_q, shreg_d;
    logic [127:0]  dat_q, dat_d;
    logic          full_q, full_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          cts_q;

    logic all_zero;
    logic all_one;
    logic bus_rd;
    logic stop_ok;
    logic stop_bad;

    assign all_zero = ~|rxd_s_q;
    assign all_one  = &rxd_s_q;
    assign ack_o    = cyc_i & stb_i & cs_i;
    assign bus_rd   = ack_o & ~we_i;

    // Two-flop synchronizer; idles high so a reset line never looks like a start symbol.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '1;
            rxd_s_q <= '1;
        end else begin
            sync1_q <= rxd;
            rxd_s_q <= sync1_q;
        end
    end

    // Symbol framing: detect start, qualify it mid-symbol, sample data at symbol end, check stop.
    always_comb begin
        state_d  = state_q;
        ctr_d    = ctr_q;
        sc_d     = sc_q;
        shreg_d  = shreg_q;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (all_zero) begin
                    state_d = ST_START;
                    ctr_d   = '0;
                end
            end
            ST_START: begin
                if (ctr_q == CTR_HALF) begin
                    // A start that is no longer low at mid-symbol was a glitch.
                    if (all_zero) begin
                        state_d = ST_DATA;
                        ctr_d   = '0;
                        sc_d    = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    ctr_d = ctr_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (ctr_q == CTR_LAST) begin
                    shreg_d = {rxd_s_q, shreg_q[127:pBitsParallel]};
                    ctr_d   = '0;
                    sc_d    = sc_q + SW'(1);
                    if (sc_q == SC_LAST) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    ctr_d = ctr_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (ctr_q == CTR_LAST) begin
                    state_d  = ST_IDLE;
                    ctr_d    = '0;
                    stop_ok  = all_one;
                    stop_bad = ~all_one;
                end else begin
                    ctr_d = ctr_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ctr_d   = '0;
            end
        endcase
    end

    // Holding register and status: a read clears, but a delivery or error on the same edge wins.
    always_comb begin
        dat_d  = dat_q;
        full_d = full_q;
        ferr_d = ferr_q;
        ovr_d  = ovr_q;
        if (bus_rd) begin
            full_d = 1'b0;
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end
        if (stop_ok) begin
            if (~full_q | bus_rd) begin
                dat_d  = shreg_q;
                full_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
        if (stop_bad) begin
            ferr_d = 1'b1;
        end
    end

    // State, counters and shift register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ctr_q   <= '0;
            sc_q    <= '0;
            shreg_q <= '1;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            sc_q    <= sc_d;
            shreg_q <= shreg_d;
        end
    end

    // Bus-visible registers; cts follows full one cycle late, so a frame in flight is never cut off.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dat_q  <= '0;
            full_q <= 1'b0;
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
            cts_q  <= 1'b1;
        end else begin
            dat_q  <= dat_d;
            full_q <= full_d;
            ferr_q <= ferr_d;
            ovr_q  <= ovr_d;
            cts_q  <= ~full_q;
        end
    end

    assign dat_o     = dat_q;
    assign full      = full_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign cts       = cts_q;

endmodule
